// File: rtl/sum_bcd_converter.sv
// Sequential double-dabble converter: turns the registered adder Sum into packed BCD,
// one bit per clock, with a Start/Busy/Done handshake and a captured overflow flag.
module sum_bcd_converter #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [WIDTH-1:0]      Bin,
    input  logic                  Ovf_In,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Valid,
    output logic [4*DIGITS-1:0]   Bcd,
    output logic                  Ovf_Out
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               hold_q, hold_d;
    logic               busy_d, done_d, valid_d, ovf_d;
    logic [BCD_W-1:0]   bcd_d;
    logic [BCD_W-1:0]   adj;

    // State and datapath registers; reset discards any partial conversion
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            hold_q    <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Valid     <= 1'b0;
            Bcd       <= '0;
            Ovf_Out   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            Busy      <= busy_d;
            Done      <= done_d;
            Valid     <= valid_d;
            Bcd       <= bcd_d;
            Ovf_Out   <= ovf_d;
        end
    end

    // Next-state, add-3 correction and shift logic
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        busy_d    = Busy;
        done_d    = 1'b0;
        valid_d   = Valid;
        bcd_d     = Bcd;
        ovf_d     = Ovf_Out;
        adj       = scratch_q;

        // Any digit >= 5 would overflow past 9 when doubled, so pre-correct by +3
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (adj[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end
        end

        case (state_q)
            IDLE: begin
                if (Start) begin
                    shift_d   = Bin;
                    hold_d    = Ovf_In;
                    scratch_d = '0;
                    cnt_d     = CNT_W'(WIDTH);
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = {adj[BCD_W-2:0], shift_q[WIDTH-1]};
                shift_d   = {shift_q[WIDTH-2:0], 1'b0};
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                bcd_d   = scratch_q;
                ovf_d   = hold_q;
                valid_d = 1'b1;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sum_bcd_converter.sv
// Bench for sum_bcd_converter: directed vector table, handshake corner cases and a
// randomised sweep checked against a divide-by-ten decimal reference.
module tb_sum_bcd_converter;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [15:0] Bin;
    logic        Ovf_In;
    logic        Busy;
    logic        Done;
    logic        Valid;
    logic [19:0] Bcd;
    logic        Ovf_Out;

    int n_cmp;
    int n_err;
    logic [19:0] last_bcd;

    typedef struct {
        logic [15:0] bin;
        logic        ovf;
        logic [19:0] bcd;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[10];

    sum_bcd_converter #(.WIDTH(16), .DIGITS(5)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Start   (Start),
        .Bin     (Bin),
        .Ovf_In  (Ovf_In),
        .Busy    (Busy),
        .Done    (Done),
        .Valid   (Valid),
        .Bcd     (Bcd),
        .Ovf_Out (Ovf_Out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Decimal reference: peel off base-10 digits arithmetically
    function automatic logic [19:0] ref_bcd(input int unsigned v);
        logic [19:0] r;
        int unsigned t;
        r = '0;
        t = v;
        for (int d = 0; d < 5; d++) begin
            r[4*d +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge: present Start for one rising edge
    task automatic launch(input logic [15:0] b, input logic o);
        Start  = 1'b1;
        Bin    = b;
        Ovf_In = o;
        @(negedge Clk);
        Start  = 1'b0;
    endtask

    // Wait for Done (bounded); optionally pulses an ignored Start at cycle poke_k
    task automatic wait_done(input string name, input int poke_k,
                             input logic [19:0] exp_bcd, input logic exp_o);
        int k;
        int busy_n;
        k = 0;
        busy_n = 0;
        while (!Done && k < 40) begin
            if (Busy) busy_n++;
            if (k == 8) check({name, "_hold"}, 32'(Bcd), 32'(last_bcd));
            Start  = (k == poke_k);
            Bin    = (k == poke_k) ? 16'd9 : 16'($urandom);
            Ovf_In = 1'($urandom);
            @(negedge Clk);
            k++;
        end
        Start = 1'b0;
        check({name, "_latency"}, 32'(k), 32'd17);
        check({name, "_busy_cycles"}, 32'(busy_n), 32'd17);
        check({name, "_bcd"}, 32'(Bcd), 32'(exp_bcd));
        check({name, "_ovf"}, 32'(Ovf_Out), 32'(exp_o));
        check({name, "_valid"}, 32'(Valid), 32'd1);
        check({name, "_busy_at_done"}, 32'(Busy), 32'd0);
        last_bcd = exp_bcd;
    endtask

    initial begin
        int done_n;
        logic [15:0] r;

        n_cmp = 0;
        n_err = 0;
        last_bcd = '0;

        vecs[0] = '{16'h0000, 1'b0, 20'h00000, 1'b0};
        vecs[1] = '{16'hFFFF, 1'b1, 20'h65535, 1'b1};
        vecs[2] = '{16'd9,     1'b0, 20'h00009, 1'b0};
        vecs[3] = '{16'd10,    1'b1, 20'h00010, 1'b1};
        vecs[4] = '{16'd99,    1'b0, 20'h00099, 1'b0};
        vecs[5] = '{16'd999,   1'b0, 20'h00999, 1'b0};
        vecs[6] = '{16'd9999,  1'b1, 20'h09999, 1'b1};
        vecs[7] = '{16'd10000, 1'b0, 20'h10000, 1'b0};
        vecs[8] = '{16'd65534, 1'b0, 20'h65534, 1'b0};
        vecs[9] = '{16'h1234,  1'b0, 20'h04660, 1'b0};

        Reset  = 1'b1;
        Start  = 1'b0;
        Bin    = '0;
        Ovf_In = 1'b0;
        repeat (3) @(negedge Clk);
        check("reset_busy", 32'(Busy), 32'd0);
        check("reset_done", 32'(Done), 32'd0);
        check("reset_valid", 32'(Valid), 32'd0);
        check("reset_bcd", 32'(Bcd), 32'd0);
        check("reset_ovf", 32'(Ovf_Out), 32'd0);
        Reset = 1'b0;
        @(negedge Clk);

        // Directed table, Start poked mid-conversion for the 1234 entry
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            launch(vecs[i].bin, vecs[i].ovf);
            check($sformatf("vec%0d_busy_start", i), 32'(Busy), 32'd1);
            wait_done($sformatf("vec%0d", i), (i == 9) ? 4 : -1, vecs[i].bcd, vecs[i].exp_ovf);
        end

        // Poked Start must not produce a second conversion
        done_n = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge Clk);
            if (Done) done_n++;
        end
        check("poke_no_second_done", 32'(done_n), 32'd0);
        check("poke_bcd_kept", 32'(Bcd), 32'h04660);

        // Start in the Done cycle is accepted
        @(negedge Clk);
        launch(16'd99, 1'b0);
        wait_done("b2b_first", -1, 20'h00099, 1'b0);
        launch(16'd100, 1'b1);
        check("b2b_busy", 32'(Busy), 32'd1);
        wait_done("b2b_second", -1, 20'h00100, 1'b1);

        // Reset mid-conversion discards everything
        @(negedge Clk);
        launch(16'd500, 1'b0);
        wait_done("pre_reset", -1, 20'h00500, 1'b0);
        @(negedge Clk);
        launch(16'd7, 1'b0);
        repeat (7) @(negedge Clk);
        Reset = 1'b1;
        #1;
        check("midreset_bcd", 32'(Bcd), 32'd0);
        check("midreset_busy", 32'(Busy), 32'd0);
        check("midreset_valid", 32'(Valid), 32'd0);
        check("midreset_ovf", 32'(Ovf_Out), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        done_n = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge Clk);
            if (Done) done_n++;
        end
        check("midreset_no_done", 32'(done_n), 32'd0);
        check("midreset_valid_stays", 32'(Valid), 32'd0);
        last_bcd = '0;

        // Randomised sweep against the decimal model
        for (int i = 0; i < 40; i++) begin
            logic o;
            r = 16'($urandom);
            o = 1'($urandom);
            @(negedge Clk);
            launch(r, o);
            wait_done($sformatf("rand%0d_%0d", i, r), -1, ref_bcd(32'(r)), o);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
